host_loader: RTL



---
 rtl/host_loader_if.sv | 24 ++
 rtl/host_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/host_loader_if.sv
// Host-link and shared-memory signal bundle for host_loader.
// master: the loader itself. slave: the host link plus the multi-core top.
interface host_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] com_data_in;
  logic [15:0] com_addr;
  logic        com_wr_en;
  logic [1:0]  status;
  logic        end_process;
  logic        done;
  logic        err;

  modport master (
    input  rx_data, rx_valid, end_process,
    output rx_ready, com_data_in, com_addr, com_wr_en, status, done, err
  );

  modport slave (
    output rx_data, rx_valid, end_process,
    input  rx_ready, com_data_in, com_addr, com_wr_en, status, done, err
  );
endinterface

// File: rtl/host_loader.sv
// Receives a SYNC/LEN/ADDR/DATA byte frame, writes the words to shared memory,
// then releases the cores and waits for end_process.
module host_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic          clk,
  input  logic          rst,
  host_loader_if.master bus
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0] ST_LOAD = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_FIN  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_ADDR_H, S_ADDR_L,
    S_DATA_H, S_DATA_L, S_WRITE, S_RUN, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    dhi_q, dhi_d;
  logic [CW-1:0] idle_q, idle_d;
  logic [15:0]   com_addr_q, com_addr_d;
  logic [15:0]   com_data_q, com_data_d;
  logic          wr_q, wr_d;
  logic [1:0]    status_q, status_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic framing, rx_ready, accept, is_sync, tmo;

  assign framing  = state_q inside {S_LEN_H, S_LEN_L, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L};
  assign rx_ready = !rst && (framing || state_q == S_IDLE || state_q == S_DONE);
  assign accept   = bus.rx_valid && rx_ready;
  assign is_sync  = accept && (bus.rx_data == SYNC_BYTE);
  // Abort on the idle cycle that would bring the count up to TIMEOUT.
  assign tmo      = framing && !accept && (idle_q == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      dhi_q      <= '0;
      idle_q     <= '0;
      com_addr_q <= '0;
      com_data_q <= '0;
      wr_q       <= 1'b0;
      status_q   <= ST_LOAD;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      dhi_q      <= dhi_d;
      idle_q     <= idle_d;
      com_addr_q <= com_addr_d;
      com_data_q <= com_data_d;
      wr_q       <= wr_d;
      status_q   <= status_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tmo) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (is_sync) state_d = S_LEN_H;
        S_LEN_H:  if (accept) state_d = S_LEN_L;
        S_LEN_L:  if (accept) state_d = S_ADDR_H;
        S_ADDR_H: if (accept) state_d = S_ADDR_L;
        S_ADDR_L: if (accept) state_d = (cnt_q == '0) ? S_RUN : S_DATA_H;
        S_DATA_H: if (accept) state_d = S_DATA_L;
        S_DATA_L: if (accept) state_d = S_WRITE;
        S_WRITE:  state_d = (cnt_q == 16'd1) ? S_RUN : S_DATA_H;
        S_RUN:    if (bus.end_process) state_d = S_DONE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    dhi_d      = dhi_q;
    idle_d     = '0;
    com_addr_d = com_addr_q;
    com_data_d = com_data_q;
    wr_d       = 1'b0;
    status_d   = status_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (framing && !accept && !tmo) idle_d = idle_q + CW'(1);
    if (tmo) begin
      err_d    = 1'b1;
      status_d = ST_LOAD;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (is_sync) status_d = ST_LOAD;
        S_LEN_H:  if (accept) cnt_d[15:8]  = bus.rx_data;
        S_LEN_L:  if (accept) cnt_d[7:0]   = bus.rx_data;
        S_ADDR_H: if (accept) addr_d[15:8] = bus.rx_data;
        S_ADDR_L: begin
          if (accept) begin
            addr_d[7:0] = bus.rx_data;
            if (cnt_q == '0) status_d = ST_RUN;
          end
        end
        S_DATA_H: if (accept) dhi_d = bus.rx_data;
        S_DATA_L: begin
          if (accept) begin
            wr_d       = 1'b1;
            com_addr_d = addr_q;
            com_data_d = {dhi_q, bus.rx_data};
          end
        end
        S_WRITE: begin
          addr_d = addr_q + 16'd1;
          cnt_d  = cnt_q - 16'd1;
          if (cnt_q == 16'd1) status_d = ST_RUN;
        end
        S_RUN: begin
          if (bus.end_process) begin
            status_d = ST_FIN;
            done_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready    = rx_ready;
  assign bus.com_addr    = com_addr_q;
  assign bus.com_data_in = com_data_q;
  assign bus.com_wr_en   = wr_q;
  assign bus.status      = status_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule
